// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and a frame strobe.
// Optional per-digit blink is compiled in with `define SEG_BLINK_EN.
//
//  state | meaning
//  S1    | DIG1 shown on AN[3]
//  S2    | DIG2 shown on AN[2]
//  S3    | DIG3 shown on AN[1]
//  S4    | DIG4 shown on AN[0]; FRAME fires on its last cycle
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] DIG1,
    input  logic [3:0] DIG2,
    input  logic [3:0] DIG3,
    input  logic [3:0] DIG4,
    input  logic       LOAD,
`ifdef SEG_BLINK_EN
    input  logic [3:0] BLINK,
`endif
    output logic [3:0] AN,
    output logic [6:0] CA,
    output logic       FRAME
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    localparam logic [1:0] S1 = 2'd0;
    localparam logic [1:0] S2 = 2'd1;
    localparam logic [1:0] S3 = 2'd2;
    localparam logic [1:0] S4 = 2'd3;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [3:0]    dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    ca_q, ca_d;
    logic          frame_q, frame_d;
    logic          wrap;
    logic [3:0]    nib_d;
    logic [3:0]    an_sel;
    logic [3:0]    blink_mask;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        slot_d = slot_q;
        if (wrap) begin
            case (slot_q)
                S1:      slot_d = S2;
                S2:      slot_d = S3;
                S3:      slot_d = S4;
                default: slot_d = S1;
            endcase
        end
    end

    always_comb begin
        dig1_d = LOAD ? DIG1 : dig1_q;
        dig2_d = LOAD ? DIG2 : dig2_q;
        dig3_d = LOAD ? DIG3 : dig3_q;
        dig4_d = LOAD ? DIG4 : dig4_q;
    end

    // Outputs are computed from next-state values so the registered AN/CA/FRAME
    // line up with the counter and slot they describe, and a load on the wrap
    // edge is shown in the new slot straight away.
    always_comb begin
        case (slot_d)
            S1:      begin nib_d = dig1_d; an_sel = 4'b0111; end
            S2:      begin nib_d = dig2_d; an_sel = 4'b1011; end
            S3:      begin nib_d = dig3_d; an_sel = 4'b1101; end
            default: begin nib_d = dig4_d; an_sel = 4'b1110; end
        endcase
        ca_d    = hex7(nib_d);
        an_d    = (cnt_d < BLANK_END) ? 4'b1111 : (an_sel | blink_mask);
        frame_d = (cnt_d == CNT_MAX) && (slot_d == S4);
    end

`ifdef SEG_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap && (slot_q == S4)) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        blink_mask = phase_d ? BLINK : 4'b0000;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    assign blink_mask = 4'b0000;
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q   <= '0;
            slot_q  <= S1;
            dig1_q  <= 4'h0;
            dig2_q  <= 4'h0;
            dig3_q  <= 4'h0;
            dig4_q  <= 4'h0;
            an_q    <= 4'b1111;
            ca_q    <= 7'b1111111;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            dig3_q  <= dig3_d;
            dig4_q  <= dig4_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
            frame_q <= frame_d;
        end
    end

    assign AN    = an_q;
    assign CA    = ca_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
// Stimulus pushes the expected AN/CA/FRAME per cycle; a negedge monitor pops and compares.
module tb_seg_scan_mux;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRM = 4 * RD;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       LOAD  = 1'b0;
    logic [3:0] DIG1 = 4'h0, DIG2 = 4'h0, DIG3 = 4'h0, DIG4 = 4'h0;
    logic [3:0] AN;
    logic [6:0] CA;
    logic       FRAME;
`ifdef SEG_BLINK_EN
    logic [3:0] BLINK = 4'b0001;
`endif

    seg_scan_mux #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .DIG1 (DIG1),
        .DIG2 (DIG2),
        .DIG3 (DIG3),
        .DIG4 (DIG4),
        .LOAD (LOAD),
`ifdef SEG_BLINK_EN
        .BLINK(BLINK),
`endif
        .AN   (AN),
        .CA   (CA),
        .FRAME(FRAME)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int         c;
        logic [3:0] an;
        logic [6:0] ca;
        logic       fr;
    } exp_t;

    exp_t sb[$];

    logic [3:0] SEL [4]     = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] CA_TBL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         fcount = 0;
    int         rel = 0;
    bit         in_rst = 1'b1;
    logic [3:0] sh [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

    always @(posedge CLOCK) cyc <= cyc + 1;

    function automatic exp_t model(input int c);
        exp_t e;
        int   d, cnt, slot;
        e.c  = c;
        e.an = 4'b1111;
        e.ca = 7'b1111111;
        e.fr = 1'b0;
        d    = c - rel;
        if (!in_rst && d > 0) begin
            cnt  = d % RD;
            slot = (d / RD) % 4;
            e.an = (cnt < BC) ? 4'b1111 : SEL[slot];
`ifdef SEG_BLINK_EN
            if (((d / FRM) / 2) % 2 == 1) e.an = e.an | BLINK;
`endif
            e.ca = CA_TBL[sh[slot]];
            e.fr = (d % FRM) == (FRM - 1);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int c, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", nm, c, got, want);
        end
    endtask

    always @(negedge CLOCK) begin : monitor
        exp_t e;
        if (FRAME === 1'b1) fcount = fcount + 1;
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            if (e.c != cyc) begin
                checks++;
                failures++;
                $display("FAIL stale_entry cycle=%0d actual_cycle=%0d required_cycle=%0d", cyc, cyc, e.c);
            end else begin
                chk("AN", cyc, {4'h0, AN}, {4'h0, e.an});
                chk("CA", cyc, {1'b0, CA}, {1'b0, e.ca});
                chk("FRAME", cyc, {7'h0, FRAME}, {7'h0, e.fr});
            end
        end
    end

    task automatic step(input logic ld, input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input logic [3:0] d4);
        @(posedge CLOCK);
        #1;
        sb.push_back(model(cyc));
        LOAD = ld;
        DIG1 = d1; DIG2 = d2; DIG3 = d3; DIG4 = d4;
        if (ld) begin
            sh[0] = d1; sh[1] = d2; sh[2] = d3; sh[3] = d4;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DIG1, DIG2, DIG3, DIG4);
    endtask

    // Idle until the next step lands on frame position p.
    task automatic idle_to(input int p);
        while (((cyc + 1 - rel) % FRM) != p) step(1'b0, DIG1, DIG2, DIG3, DIG4);
    endtask

    task automatic do_reset(input int hold);
        @(posedge CLOCK);
        #1;
        RESET  = 1'b0;
        LOAD   = 1'b0;
        in_rst = 1'b1;
        sh     = '{4'h0, 4'h0, 4'h0, 4'h0};
        sb.push_back(model(cyc));
        idle(hold);
        @(posedge CLOCK);
        #1;
        RESET  = 1'b1;
        in_rst = 1'b0;
        rel    = cyc;
        sb.push_back(model(cyc));
    endtask

    initial begin : stimulus
        idle(3);
        @(posedge CLOCK);
        #1;
        RESET  = 1'b1;
        in_rst = 1'b0;
        rel    = cyc;
        sb.push_back(model(cyc));
        idle(40);

        idle_to(20);
        step(1'b1, 4'h3, 4'h5, 4'h0, 4'h8);
        idle(40);

        fcount = 0;
        idle(3 * FRM);
        @(negedge CLOCK);
        chk("frame_count_96", cyc, 8'(fcount), 8'd3);

        idle_to(7);
        step(1'b1, 4'h3, 4'hF, 4'h0, 4'h8);
        step(1'b0, 4'h3, 4'hF, 4'h0, 4'h8);
        for (int i = 0; i < 40; i++)
            step(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)),
                 4'($urandom_range(15)), 4'($urandom_range(15)));

        idle_to(13);
        do_reset(2);
        idle(40);

`ifdef SEG_BLINK_EN
        idle(6 * FRM);
`endif
        @(negedge CLOCK);
        @(negedge CLOCK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
